// File: rtl/syn_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : syn_fifo_ctrl
//  Purpose  : Pointer/flag controller that turns the syn_16x8 dual-port RAM
//             into a synchronous FIFO with occupancy and sticky error flags.
//  Revision : 1.0  initial release
// ============================================================================
module syn_fifo_ctrl #(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_DEPTH  = 16,
    parameter int ADDR_SIZE  = 4,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [RAM_WIDTH-1:0] data_in,
    input  logic                 clr_err,
    output logic                 ram_write,
    output logic                 ram_read,
    output logic [ADDR_SIZE-1:0] ram_write_addr,
    output logic [ADDR_SIZE-1:0] ram_read_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    output logic [ADDR_SIZE:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 rd_valid,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR_SIZE:0] c_DEPTH      = (ADDR_SIZE+1)'(RAM_DEPTH);
    localparam logic [ADDR_SIZE:0] c_AFULL_LVL  = (ADDR_SIZE+1)'(AFULL_LVL);
    localparam logic [ADDR_SIZE:0] c_AEMPTY_LVL = (ADDR_SIZE+1)'(AEMPTY_LVL);
    localparam logic [ADDR_SIZE:0] c_ONE        = (ADDR_SIZE+1)'(1);

    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic                 r_rd_valid;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = pop & ~w_empty;
    // A push into a full FIFO is still legal when a pop frees the slot this cycle.
    assign w_push_ok = push & (~w_full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_ok;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase

            // Setting outranks clearing so an error in the clear cycle is not lost.
            if (push & w_full & ~pop) r_overflow <= 1'b1;
            else if (clr_err)         r_overflow <= 1'b0;

            if (pop & w_empty)        r_underflow <= 1'b1;
            else if (clr_err)         r_underflow <= 1'b0;
        end
    end

    assign ram_write      = w_push_ok;
    assign ram_read       = w_pop_ok;
    assign ram_write_addr = r_wr_ptr;
    assign ram_read_addr  = r_rd_ptr;
    assign ram_data_in    = data_in;
    assign count          = r_count;
    assign full           = w_full;
    assign empty          = w_empty;
    assign almost_full    = (r_count >= c_AFULL_LVL);
    assign almost_empty   = (r_count <= c_AEMPTY_LVL);
    assign rd_valid       = r_rd_valid;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_syn_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_syn_fifo_ctrl
//  Purpose  : Self-checking bench for syn_fifo_ctrl with a behavioural RAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_syn_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       clr_err = 1'b0;
    logic       ram_write, ram_read;
    logic [3:0] ram_write_addr, ram_read_addr;
    logic [7:0] ram_data_in;
    logic [4:0] count;
    logic       full, empty, almost_full, almost_empty;
    logic       rd_valid, overflow, underflow;

    syn_fifo_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .push           (push),
        .pop            (pop),
        .data_in        (data_in),
        .clr_err        (clr_err),
        .ram_write      (ram_write),
        .ram_read       (ram_read),
        .ram_write_addr (ram_write_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_data_in    (ram_data_in),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .almost_full    (almost_full),
        .almost_empty   (almost_empty),
        .rd_valid       (rd_valid),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    // syn_16x8 stand-in: synchronous read-before-write, reset clears data_out.
    logic [7:0] mem [16];
    logic [7:0] ram_dout;
    always @(posedge clk) begin
        if (reset) begin
            ram_dout <= 8'h00;
        end else begin
            if (ram_read)  ram_dout <= mem[ram_read_addr];
            if (ram_write) mem[ram_write_addr] <= ram_data_in;
        end
    end

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb [$];
    int         m_count = 0;
    logic [3:0] m_wptr = 4'd0;
    logic [3:0] m_rptr = 4'd0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == 16));
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("almost_full", 32'(almost_full), 32'(m_count >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        m_count = 0; m_wptr = 4'd0; m_rptr = 4'd0; m_ovf = 1'b0; m_unf = 1'b0;
        sb.delete();
        check_state();
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_waddr", 32'(ram_write_addr), 32'd0);
        chk("rst_raddr", 32'(ram_read_addr), 32'd0);
    endtask

    task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c);
        logic exp_w, exp_r, m_full, m_empty;
        @(negedge clk);
        push = p; pop = q; data_in = d; clr_err = c;
        #1;
        m_full  = (m_count == 16);
        m_empty = (m_count == 0);
        exp_r = q && !m_empty;
        exp_w = p && (!m_full || exp_r);
        chk("ram_write", 32'(ram_write), 32'(exp_w));
        chk("ram_read", 32'(ram_read), 32'(exp_r));
        chk("waddr", 32'(ram_write_addr), 32'(m_wptr));
        chk("raddr", 32'(ram_read_addr), 32'(m_rptr));
        chk("ram_data_in", 32'(ram_data_in), 32'(d));
        if (exp_w) sb.push_back(d);
        @(posedge clk); #1;
        if (p && m_full && !q) m_ovf = 1'b1;
        else if (c)            m_ovf = 1'b0;
        if (q && m_empty)      m_unf = 1'b1;
        else if (c)            m_unf = 1'b0;
        if (exp_w) m_wptr = m_wptr + 4'd1;
        if (exp_r) m_rptr = m_rptr + 4'd1;
        m_count = m_count + int'(exp_w) - int'(exp_r);
        check_state();
        chk("rd_valid", 32'(rd_valid), 32'(exp_r));
        if (rd_valid) begin
            if (sb.size() == 0) chk("sb_underrun", 32'd1, 32'd0);
            else                chk("rdata", 32'(ram_dout), 32'(sb.pop_front()));
        end
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();

        // fill to full, then overflow
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h11 + 8'(i), 1'b0);
        step(1'b1, 1'b0, 8'h99, 1'b0);

        // drain in order, then underflow, then clear both
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // pointer wrap past 15
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h30 + 8'(k * 16 + i), 1'b0);
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        end

        // full + push + pop, then empty + push + pop
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // reset mid-stream discards contents
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h70 + 8'(i), 1'b0);
        do_reset();
        step(1'b1, 1'b0, 8'h77, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // random traffic including clears
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 9) == 0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
